// File: rtl/i2s_wb_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : i2s_wb_tx_fifo
// Brief    : Wishbone-fed I2S slave-timed transmitter. Stereo pairs are staged
//            through a FIFO and serialised against external SCK/WS.
//            Define I2S_TX_LJ_EN for left-justified (zero-delay) framing.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_wb_tx_fifo #(
    parameter int SAMPLE_W = 16,
    parameter int FIFO_AW  = 3
) (
    input  logic        i2s_clk_i,
    input  logic        i2s_rst_i,
    input  logic [31:0] wbs_data_i,
    output logic [31:0] wbs_data_o,
    input  logic [31:0] wbs_addr_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        wbs_rty_o,
    input  logic        i2s_sck_i,
    input  logic        i2s_ws_i,
    output logic        i2s_sd_o
);
    localparam int             DEPTH    = 2**FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_FRAME = 2'd1, RUN = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [2:0]            sck_sync_q, sck_sync_d;
    logic [1:0]            ws_sync_q, ws_sync_d;
    logic                  ws_q, ws_d;
    logic                  pend_q, pend_d;
    logic [SAMPLE_W-1:0]   nxt_q, nxt_d;
    logic [SAMPLE_W-1:0]   hold_r_q, hold_r_d;
    logic [SAMPLE_W-1:0]   sh_q, sh_d;
    logic [SAMPLE_W-1:0]   stage_l_q, stage_l_d;
    logic                  sd_q, sd_d;
    logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]      level_q, level_d;
    logic                  underrun_q, underrun_d, overflow_q, overflow_d;
    logic [1:0]            ctrl_q, ctrl_d;
    logic                  ack_q, ack_d, err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [2*SAMPLE_W-1:0] mem_q [DEPTH];

    logic                  w_sck_rise, w_sck_fall, w_ws_smp, w_ws_fall, w_ws_rise;
    logic                  w_en, w_mute, w_left, w_right, w_empty, w_full, w_pop, w_push;
    logic                  w_req, w_wr, w_ovf, w_load;
    logic [1:0]            w_addr;
    logic [2*SAMPLE_W-1:0] w_rd;
    logic [SAMPLE_W-1:0]   w_slot_val, w_load_val;
    logic [31:0]           w_status;
    logic                  w_unused;

    assign w_sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign w_sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
`ifdef I2S_TX_LJ_EN
    assign w_ws_smp = w_sck_fall;
    assign w_unused = ^{wbs_sel_i, wbs_addr_i, wbs_data_i, pend_q, nxt_q};
`else
    assign w_ws_smp = w_sck_rise;
    assign w_unused = ^{wbs_sel_i, wbs_addr_i, wbs_data_i};
`endif
    assign w_ws_fall  = w_ws_smp & ws_q & ~ws_sync_q[1];
    assign w_ws_rise  = w_ws_smp & ~ws_q & ws_sync_q[1];
    assign w_en       = ctrl_q[0];
    assign w_mute     = ctrl_q[1];
    assign w_left     = w_en && (state_q != IDLE) && w_ws_fall;
    assign w_right    = w_en && (state_q == RUN) && w_ws_rise;
    assign w_empty    = (level_q == '0);
    assign w_full     = (level_q == FULL_LVL);
    assign w_pop      = w_left && !w_empty;
    assign w_rd       = mem_q[rd_ptr_q];
    assign w_slot_val = w_left ? (w_empty ? '0 : w_rd[SAMPLE_W-1:0]) : hold_r_q;

    assign w_req  = wbs_cyc_i & wbs_stb_i & ~ack_q & ~err_q;
    assign w_addr = wbs_addr_i[3:2];
    assign w_wr   = w_req & wbs_we_i;
    // A pop in the same cycle frees a slot, so a full FIFO only rejects without one.
    assign w_ovf  = w_wr && (w_addr == 2'd1) && w_full && !w_pop;
    assign w_push = w_wr && (w_addr == 2'd1) && !w_ovf;

`ifdef I2S_TX_LJ_EN
    assign w_load     = w_left | w_right;
    assign w_load_val = w_slot_val;
`else
    assign w_load     = pend_q & w_sck_fall;
    assign w_load_val = nxt_q;
`endif

    always_comb begin
        sck_sync_d = {sck_sync_q[1:0], i2s_sck_i};
        ws_sync_d  = {ws_sync_q[0], i2s_ws_i};
        ws_d       = w_ws_smp ? ws_sync_q[1] : ws_q;
        state_d    = state_q;
        pend_d     = pend_q;
        nxt_d      = nxt_q;
        hold_r_d   = hold_r_q;
        sh_d       = sh_q;
        sd_d       = sd_q;
        stage_l_d  = stage_l_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        underrun_d = underrun_q;
        overflow_d = overflow_q;
        ctrl_d     = ctrl_q;
        ack_d      = w_req & ~w_ovf;
        err_d      = w_ovf;
        rdata_d    = '0;
        w_status   = '0;

        case (state_q)
            IDLE:       if (w_en) state_d = WAIT_FRAME;
            WAIT_FRAME: if (w_left) state_d = RUN;
            RUN:        state_d = RUN;
            default:    state_d = IDLE;
        endcase
        if (!w_en) state_d = IDLE;

        if (w_left) hold_r_d = w_empty ? '0 : w_rd[2*SAMPLE_W-1:SAMPLE_W];
`ifndef I2S_TX_LJ_EN
        // Standard framing: capture at the WS edge, start shifting at the next SCK fall.
        if (w_left || w_right) begin
            pend_d = 1'b1;
            nxt_d  = w_slot_val;
        end else if (w_load) begin
            pend_d = 1'b0;
        end
`endif
        if (w_load) begin
            sd_d = w_load_val[SAMPLE_W-1] & ~w_mute;
            sh_d = {w_load_val[SAMPLE_W-2:0], 1'b0};
        end else if (state_q == RUN && w_sck_fall) begin
            sd_d = sh_q[SAMPLE_W-1] & ~w_mute;
            sh_d = {sh_q[SAMPLE_W-2:0], 1'b0};
        end
        if (!w_en || state_q == IDLE) begin
            sd_d   = 1'b0;
            pend_d = 1'b0;
        end

        if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (w_wr && w_addr == 2'd0) stage_l_d = wbs_data_i[SAMPLE_W-1:0];
        if (w_wr && w_addr == 2'd3) ctrl_d = wbs_data_i[1:0];
        if (w_wr && w_addr == 2'd2 && wbs_data_i[18]) underrun_d = 1'b0;
        if (w_wr && w_addr == 2'd2 && wbs_data_i[19]) overflow_d = 1'b0;
        if (w_left && w_empty) underrun_d = 1'b1;
        if (w_ovf) overflow_d = 1'b1;

        w_status[FIFO_AW:0] = level_q;
        w_status[16]        = w_empty;
        w_status[17]        = w_full;
        w_status[18]        = underrun_q;
        w_status[19]        = overflow_q;
        if (w_req && !wbs_we_i) begin
            case (w_addr)
                2'd2:    rdata_d = w_status;
                2'd3:    rdata_d = {30'd0, ctrl_q};
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge i2s_clk_i or posedge i2s_rst_i) begin
        if (i2s_rst_i) begin
            state_q    <= IDLE;
            sck_sync_q <= '0;
            ws_sync_q  <= '0;
            ws_q       <= 1'b0;
            pend_q     <= 1'b0;
            nxt_q      <= '0;
            hold_r_q   <= '0;
            sh_q       <= '0;
            sd_q       <= 1'b0;
            stage_l_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            ctrl_q     <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            sck_sync_q <= sck_sync_d;
            ws_sync_q  <= ws_sync_d;
            ws_q       <= ws_d;
            pend_q     <= pend_d;
            nxt_q      <= nxt_d;
            hold_r_q   <= hold_r_d;
            sh_q       <= sh_d;
            sd_q       <= sd_d;
            stage_l_q  <= stage_l_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            ctrl_q     <= ctrl_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    always_ff @(posedge i2s_clk_i) begin
        if (w_push) mem_q[wr_ptr_q] <= {wbs_data_i[SAMPLE_W-1:0], stage_l_q};
    end

    assign wbs_data_o = rdata_q;
    assign wbs_ack_o  = ack_q;
    assign wbs_err_o  = err_q;
    assign wbs_rty_o  = 1'b0;
    assign i2s_sd_o   = sd_q;

endmodule
`default_nettype wire
